// File: rtl/rect_engine_if.sv
// Port bundle for rect_engine: command handshake from the decoder plus the framebuffer port-B request bus.
// slave is the engine's view; master is the environment (command source and framebuffer).
interface rect_engine_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [8:0] cmd_x0;
    logic [8:0] cmd_x1;
    logic [7:0] cmd_y0;
    logic [7:0] cmd_y1;
    logic       done;
    logic [8:0] x_b;
    logic [7:0] y_b;
    logic       read_b;
    logic       write_b;
    logic       in_b;
    logic       out_b;
    logic       rdy_b;

    modport slave (
        input  cmd_valid, cmd_op, cmd_x0, cmd_x1, cmd_y0, cmd_y1, out_b, rdy_b,
        output cmd_ready, done, x_b, y_b, read_b, write_b, in_b
    );

    modport master (
        output cmd_valid, cmd_op, cmd_x0, cmd_x1, cmd_y0, cmd_y1, out_b, rdy_b,
        input  cmd_ready, done, x_b, y_b, read_b, write_b, in_b
    );
endinterface

// File: rtl/rect_engine.sv
// Rectangle raster engine: fills or inverts a clipped rectangle of the 320x200 1-bit framebuffer
// one pixel at a time over port B, walking y outer / x inner.
module rect_engine (
    input  logic         clk_b,
    input  logic         reset,
    rect_engine_if.slave bus
);
    localparam int unsigned XW = 9;
    localparam int unsigned YW = 8;
    localparam logic [XW-1:0] X_LAST = XW'(319);
    localparam logic [YW-1:0] Y_LAST = YW'(199);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_WR_REQ,
        S_WR_WAIT,
        S_FIN
    } state_t;

    state_t        r_state;
    state_t        w_next;

    logic [1:0]    r_op;
    logic [XW-1:0] r_xmin;
    logic [XW-1:0] r_xmax;
    logic [YW-1:0] r_ymin;
    logic [YW-1:0] r_ymax;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;

    logic          r_cmd_ready;
    logic          r_done;
    logic          r_read_b;
    logic          r_write_b;
    logic          r_in_b;

    logic          w_accept;
    logic          w_empty;
    logic          w_last;
    logic          w_advance;
    logic          w_in_next;
    logic [XW-1:0] w_xmin;
    logic [XW-1:0] w_xhi;
    logic [XW-1:0] w_xmax;
    logic [YW-1:0] w_ymin;
    logic [YW-1:0] w_yhi;
    logic [YW-1:0] w_ymax;

    // Normalise corner order and clip the far edge to the screen
    assign w_accept = bus.cmd_valid && r_cmd_ready;
    assign w_xmin   = (bus.cmd_x0 < bus.cmd_x1) ? bus.cmd_x0 : bus.cmd_x1;
    assign w_xhi    = (bus.cmd_x0 < bus.cmd_x1) ? bus.cmd_x1 : bus.cmd_x0;
    assign w_xmax   = (w_xhi > X_LAST) ? X_LAST : w_xhi;
    assign w_ymin   = (bus.cmd_y0 < bus.cmd_y1) ? bus.cmd_y0 : bus.cmd_y1;
    assign w_yhi    = (bus.cmd_y0 < bus.cmd_y1) ? bus.cmd_y1 : bus.cmd_y0;
    assign w_ymax   = (w_yhi > Y_LAST) ? Y_LAST : w_yhi;
    assign w_empty  = (w_xmin > X_LAST) || (w_ymin > Y_LAST) || (bus.cmd_op == 2'b11);
    assign w_last   = (r_x == r_xmax) && (r_y == r_ymax);

    always_ff @(posedge clk_b) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // w_in_next carries the write data into the WR_REQ that follows; for invert it is the latched ~out_b
    always_comb begin
        w_next    = r_state;
        w_advance = 1'b0;
        w_in_next = r_in_b;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_empty) begin
                        w_next = S_FIN;
                    end else if (bus.cmd_op == 2'b10) begin
                        w_next = S_RD_REQ;
                    end else begin
                        w_next    = S_WR_REQ;
                        w_in_next = bus.cmd_op[0];
                    end
                end
            end
            S_RD_REQ: begin
                if (bus.rdy_b) w_next = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (bus.rdy_b) begin
                    w_next    = S_WR_REQ;
                    w_in_next = ~bus.out_b;
                end
            end
            S_WR_REQ: begin
                if (bus.rdy_b) w_next = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                if (bus.rdy_b) begin
                    if (w_last) begin
                        w_next = S_FIN;
                    end else begin
                        w_advance = 1'b1;
                        if (r_op == 2'b10) begin
                            w_next = S_RD_REQ;
                        end else begin
                            w_next    = S_WR_REQ;
                            w_in_next = r_op[0];
                        end
                    end
                end
            end
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_b) begin
        if (w_accept) begin
            r_op   <= bus.cmd_op;
            r_xmin <= w_xmin;
            r_xmax <= w_xmax;
            r_ymin <= w_ymin;
            r_ymax <= w_ymax;
        end
    end

    // Outputs are registered from the next state so strobes and address change only on clock edges
    always_ff @(posedge clk_b) begin
        if (reset) begin
            r_cmd_ready <= 1'b1;
            r_done      <= 1'b0;
            r_read_b    <= 1'b0;
            r_write_b   <= 1'b0;
            r_in_b      <= 1'b0;
            r_x         <= '0;
            r_y         <= '0;
        end else begin
            r_cmd_ready <= (w_next == S_IDLE);
            r_done      <= (w_next == S_FIN);
            r_read_b    <= (w_next == S_RD_REQ);
            r_write_b   <= (w_next == S_WR_REQ);
            r_in_b      <= w_in_next;
            if (w_accept) begin
                r_x <= w_xmin;
                r_y <= w_ymin;
            end else if (w_advance) begin
                if (r_x == r_xmax) begin
                    r_x <= r_xmin;
                    r_y <= r_y + YW'(1);
                end else begin
                    r_x <= r_x + XW'(1);
                end
            end
        end
    end

    assign bus.cmd_ready = r_cmd_ready;
    assign bus.done      = r_done;
    assign bus.read_b    = r_read_b;
    assign bus.write_b   = r_write_b;
    assign bus.in_b      = r_in_b;
    assign bus.x_b       = r_x;
    assign bus.y_b       = r_y;
endmodule

// File: tb/tb_rect_engine.sv
// Self-checking bench for rect_engine: a timed framebuffer model plus a pixel-list reference model
// built from the clipped rectangle in raster order.
module tb_rect_engine;
    logic clk_b = 1'b0;
    logic reset;
    always #5 clk_b = ~clk_b;

    rect_engine_if bus ();
    rect_engine dut (.clk_b(clk_b), .reset(reset), .bus(bus));

    int total;
    int bad;
    int cyc;
    int viol;
    int done_cnt;
    int rd_taken;
    int wr_taken;

    bit          mem     [0:319][0:199];
    bit          ref_mem [0:319][0:199];
    logic [17:0] wr_log[$];
    logic [17:0] exp_q[$];

    logic       fb_rdy;
    logic       fb_out;
    int         fb_cnt;
    logic       poke_en;
    logic       poke_v;
    logic [8:0] poke_x;
    logic [7:0] poke_y;

    assign bus.rdy_b = fb_rdy;
    assign bus.out_b = fb_out;

    // Framebuffer: write busy 1 cycle, read busy 2 cycles with data when idle again
    always @(posedge clk_b) begin
        cyc <= cyc + 1;
        if (poke_en) mem[poke_x][poke_y] <= poke_v;
        if (reset) begin
            fb_rdy <= 1'b1;
            fb_cnt <= 0;
            fb_out <= 1'b0;
        end else if (fb_cnt > 0) begin
            fb_cnt <= fb_cnt - 1;
            if (fb_cnt == 1) fb_rdy <= 1'b1;
        end else if (fb_rdy && bus.write_b === 1'b1) begin
            if (bus.x_b < 9'd320 && bus.y_b < 8'd200) mem[bus.x_b][bus.y_b] <= bus.in_b;
            wr_log.push_back({bus.x_b, bus.y_b, bus.in_b});
            wr_taken <= wr_taken + 1;
            fb_rdy   <= 1'b0;
            fb_cnt   <= 1;
        end else if (fb_rdy && bus.read_b === 1'b1) begin
            if (bus.x_b < 9'd320 && bus.y_b < 8'd200) fb_out <= mem[bus.x_b][bus.y_b];
            rd_taken <= rd_taken + 1;
            fb_rdy   <= 1'b0;
            fb_cnt   <= 2;
        end
    end

    logic       p_rd, p_wr, p_in, p_rdy;
    logic [8:0] p_x;
    logic [7:0] p_y;

    // Protocol monitor: one strobe at a time, on-screen address, request held steady until taken
    always @(posedge clk_b) begin
        if (reset) begin
            p_rd  <= 1'b0;
            p_wr  <= 1'b0;
            p_in  <= 1'b0;
            p_rdy <= 1'b1;
            p_x   <= '0;
            p_y   <= '0;
        end else begin
            if (bus.done === 1'b1) done_cnt <= done_cnt + 1;
            if (bus.read_b === 1'b1 && bus.write_b === 1'b1)
                viol <= viol + 1;
            else if ((bus.read_b === 1'b1 || bus.write_b === 1'b1) && (bus.x_b > 9'd319 || bus.y_b > 8'd199))
                viol <= viol + 1;
            else if ((p_rd || p_wr) && !p_rdy &&
                     ({bus.read_b, bus.write_b, bus.x_b, bus.y_b, bus.write_b & bus.in_b} !==
                      {p_rd, p_wr, p_x, p_y, p_wr & p_in}))
                viol <= viol + 1;
            p_rd  <= bus.read_b;
            p_wr  <= bus.write_b;
            p_in  <= bus.in_b;
            p_x   <= bus.x_b;
            p_y   <= bus.y_b;
            p_rdy <= bus.rdy_b;
        end
    end

    // Reference model: expected write list and updated memory image for the first 'limit' pixels
    task automatic model_cmd(input logic [1:0] op, input int x0, input int x1, input int y0, input int y1,
                             input int limit, output int n, output int cpp);
        int xl, xh, yl, yh;
        bit d;
        exp_q.delete();
        n   = 0;
        cpp = (op == 2'd2) ? 7 : 3;
        xl  = (x0 < x1) ? x0 : x1;
        xh  = (x0 < x1) ? x1 : x0;
        yl  = (y0 < y1) ? y0 : y1;
        yh  = (y0 < y1) ? y1 : y0;
        if (xh > 319) xh = 319;
        if (yh > 199) yh = 199;
        if (op == 2'd3 || xl > 319 || yl > 199) return;
        for (int y = yl; y <= yh; y++) begin
            for (int x = xl; x <= xh; x++) begin
                d = (op == 2'd2) ? ~ref_mem[x][y] : bit'(op[0]);
                if (n < limit) begin
                    exp_q.push_back({9'(x), 8'(y), d});
                    ref_mem[x][y] = d;
                end
                n++;
            end
        end
    endtask

    task automatic poke(input int x, input int y, input bit v);
        @(negedge clk_b);
        poke_en = 1'b1;
        poke_x  = 9'(x);
        poke_y  = 8'(y);
        poke_v  = v;
        ref_mem[x][y] = v;
        @(negedge clk_b);
        poke_en = 1'b0;
    endtask

    task automatic issue(input logic [1:0] op, input int x0, input int x1, input int y0, input int y1,
                         output int c);
        @(negedge clk_b);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_x0    = 9'(x0);
        bus.cmd_x1    = 9'(x1);
        bus.cmd_y0    = 8'(y0);
        bus.cmd_y1    = 8'(y1);
        c = cyc;
        @(negedge clk_b);
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'($urandom);
        bus.cmd_x0    = 9'($urandom);
        bus.cmd_y0    = 8'($urandom);
    endtask

    task automatic wait_done(output int d);
        d = -1;
        for (int i = 0; i < 6000; i++) begin
            if (bus.done === 1'b1) begin
                d = cyc;
                break;
            end
            @(negedge clk_b);
        end
    endtask

    task automatic check_region(input string name, input int xl, input int xh, input int yl, input int yh);
        int errs;
        errs = 0;
        for (int y = yl; y <= yh && y < 200; y++)
            for (int x = xl; x <= xh && x < 320; x++)
                if (mem[x][y] !== ref_mem[x][y]) errs++;
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL %s memory: %0d pixels differ, expected 0", name, errs);
        end
    endtask

    task automatic run_cmd(input string name, input logic [1:0] op, input int x0, input int x1,
                           input int y0, input int y1);
        int c, d, n, cpp, w0, r0, v0, errs, first;
        w0 = wr_log.size();
        r0 = rd_taken;
        v0 = viol;
        model_cmd(op, x0, x1, y0, y1, 1 << 30, n, cpp);
        issue(op, x0, x1, y0, y1, c);
        total++;
        if (bus.cmd_ready !== 1'b0) begin
            bad++;
            $display("FAIL %s cmd_ready after accept: got %b expected 0", name, bus.cmd_ready);
        end
        wait_done(d);
        total++;
        if (d != c + 1 + cpp * n) begin
            bad++;
            $display("FAIL %s done cycle: got %0d expected %0d (-1 = timeout)", name, d, c + 1 + cpp * n);
        end
        total++;
        if (wr_log.size() - w0 != n) begin
            bad++;
            $display("FAIL %s write count: got %0d expected %0d", name, wr_log.size() - w0, n);
        end
        errs  = 0;
        first = -1;
        for (int i = 0; i < exp_q.size() && w0 + i < wr_log.size(); i++)
            if (wr_log[w0 + i] !== exp_q[i]) begin
                errs++;
                if (first < 0) first = i;
            end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL %s write #%0d: got x=%0d y=%0d d=%0d expected x=%0d y=%0d d=%0d", name, first,
                     wr_log[w0 + first][17:9], wr_log[w0 + first][8:1], wr_log[w0 + first][0],
                     exp_q[first][17:9], exp_q[first][8:1], exp_q[first][0]);
        end
        total++;
        if (rd_taken - r0 != ((op == 2'd2) ? n : 0)) begin
            bad++;
            $display("FAIL %s read count: got %0d expected %0d", name, rd_taken - r0, (op == 2'd2) ? n : 0);
        end
        @(negedge clk_b);
        total++;
        if ({bus.done, bus.cmd_ready} !== 2'b01) begin
            bad++;
            $display("FAIL %s after done: got done/ready=%b expected 01", name, {bus.done, bus.cmd_ready});
        end
        total++;
        if (viol != v0) begin
            bad++;
            $display("FAIL %s protocol: got %0d violations expected 0", name, viol - v0);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk_b);
        total++;
        if ({bus.cmd_ready, bus.done, bus.read_b, bus.write_b, bus.in_b} !== 5'b10000) begin
            bad++;
            $display("FAIL reset flags: got %b expected 10000",
                     {bus.cmd_ready, bus.done, bus.read_b, bus.write_b, bus.in_b});
        end
        total++;
        if ({bus.x_b, bus.y_b} !== 17'd0) begin
            bad++;
            $display("FAIL reset address: got x=%0d y=%0d expected 0,0", bus.x_b, bus.y_b);
        end
        reset = 1'b0;
    endtask

    task automatic test_single_fill();
        run_cmd("single_fill", 2'd1, 5, 5, 7, 7);
        total++;
        if (mem[5][7] !== 1'b1) begin
            bad++;
            $display("FAIL single_fill readback: got %b expected 1", mem[5][7]);
        end
    endtask

    task automatic test_swapped();
        run_cmd("swapped", 2'd0, 12, 10, 3, 2);
    endtask

    task automatic test_invert();
        poke(0, 0, 1'b1);
        poke(1, 0, 1'b0);
        run_cmd("invert", 2'd2, 0, 1, 0, 0);
        total++;
        if ({mem[0][0], mem[1][0]} !== 2'b01) begin
            bad++;
            $display("FAIL invert result: got %b%b expected 01", mem[0][0], mem[1][0]);
        end
    endtask

    task automatic test_clip();
        run_cmd("clip", 2'd1, 300, 400, 190, 250);
        check_region("clip", 300, 319, 190, 199);
    endtask

    task automatic test_back_to_back();
        int c, d, n, cpp, s0, w0, early;
        // Empty command with cmd_valid held and switched to a no-op: both finish without strobes
        s0 = wr_taken + rd_taken;
        @(negedge clk_b);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'd1;
        bus.cmd_x0    = 9'd330;
        bus.cmd_x1    = 9'd340;
        bus.cmd_y0    = 8'd0;
        bus.cmd_y1    = 8'd5;
        @(negedge clk_b);
        bus.cmd_op = 2'd3;
        total++;
        if ({bus.done, bus.cmd_ready} !== 2'b10) begin
            bad++;
            $display("FAIL empty done at c+1: got done/ready=%b expected 10", {bus.done, bus.cmd_ready});
        end
        @(negedge clk_b);
        total++;
        if ({bus.done, bus.cmd_ready} !== 2'b01) begin
            bad++;
            $display("FAIL empty idle at c+2: got done/ready=%b expected 01", {bus.done, bus.cmd_ready});
        end
        @(negedge clk_b);
        bus.cmd_valid = 1'b0;
        total++;
        if (bus.done !== 1'b1) begin
            bad++;
            $display("FAIL noop done: got %b expected 1", bus.done);
        end
        @(negedge clk_b);
        total++;
        if (wr_taken + rd_taken != s0) begin
            bad++;
            $display("FAIL empty strobes: got %0d expected 0", wr_taken + rd_taken - s0);
        end

        // Fill with the next command held valid during the busy period
        model_cmd(2'd1, 20, 22, 30, 30, 1 << 30, n, cpp);
        w0 = wr_log.size();
        @(negedge clk_b);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'd1;
        bus.cmd_x0    = 9'd20;
        bus.cmd_x1    = 9'd22;
        bus.cmd_y0    = 8'd30;
        bus.cmd_y1    = 8'd30;
        c = cyc;
        @(negedge clk_b);
        bus.cmd_op = 2'd3;
        d     = -1;
        early = 0;
        for (int i = 0; i < 200; i++) begin
            if (bus.done === 1'b1) begin
                d = cyc;
                break;
            end
            if (bus.cmd_ready !== 1'b0) early++;
            @(negedge clk_b);
        end
        total++;
        if (d != c + 1 + cpp * n || early != 0) begin
            bad++;
            $display("FAIL held fill: got done=%0d early_ready=%0d expected done=%0d early_ready=0",
                     d, early, c + 1 + cpp * n);
        end
        @(negedge clk_b);
        total++;
        if (bus.cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL held idle: got cmd_ready=%b expected 1", bus.cmd_ready);
        end
        @(negedge clk_b);
        bus.cmd_valid = 1'b0;
        total++;
        if (bus.done !== 1'b1 || wr_log.size() - w0 != n) begin
            bad++;
            $display("FAIL held second: got done=%b writes=%0d expected done=1 writes=%0d",
                     bus.done, wr_log.size() - w0, n);
        end
        @(negedge clk_b);
    endtask

    task automatic test_reset_mid();
        int c, n, cpp, w0, s0, d0, strobes, errs;
        for (int y = 50; y <= 53; y++)
            for (int x = 40; x <= 43; x++) poke(x, y, bit'($urandom_range(0, 1)));
        model_cmd(2'd2, 40, 43, 50, 53, 9, n, cpp);
        w0 = wr_log.size();
        issue(2'd2, 43, 40, 53, 50, c);
        for (int i = 0; i < 500 && wr_log.size() - w0 < 9; i++) @(negedge clk_b);
        repeat (3) @(negedge clk_b);
        reset = 1'b1;
        @(negedge clk_b);
        d0 = done_cnt;
        total++;
        if ({bus.cmd_ready, bus.done, bus.read_b, bus.write_b} !== 4'b1000) begin
            bad++;
            $display("FAIL reset_mid state: got ready/done/rd/wr=%b expected 1000",
                     {bus.cmd_ready, bus.done, bus.read_b, bus.write_b});
        end
        reset   = 1'b0;
        s0      = wr_taken + rd_taken;
        strobes = 0;
        repeat (20) begin
            @(negedge clk_b);
            if (bus.read_b !== 1'b0 || bus.write_b !== 1'b0) strobes++;
        end
        total++;
        if (strobes != 0 || wr_taken + rd_taken != s0 || done_cnt != d0) begin
            bad++;
            $display("FAIL reset_mid quiet: got strobes=%0d taken=%0d dones=%0d expected 0 0 0",
                     strobes, wr_taken + rd_taken - s0, done_cnt - d0);
        end
        errs = 0;
        for (int i = 0; i < 9; i++)
            if (w0 + i >= wr_log.size() || wr_log[w0 + i] !== exp_q[i]) errs++;
        total++;
        if (errs != 0 || wr_log.size() - w0 != 9) begin
            bad++;
            $display("FAIL reset_mid writes: got %0d writes, %0d wrong, expected 9 writes 0 wrong",
                     wr_log.size() - w0, errs);
        end
        check_region("reset_mid", 40, 43, 50, 53);
        run_cmd("after_reset_fill", 2'd0, 40, 43, 50, 53);
        check_region("after_reset_fill", 40, 43, 50, 53);
    endtask

    task automatic test_random();
        int x0, x1, y0, y1, xl, xh, yl, yh;
        logic [1:0] op;
        for (int t = 0; t < 8; t++) begin
            op = 2'($urandom_range(0, 3));
            x0 = $urandom_range(0, 335);
            x1 = x0 + int'($urandom_range(0, 6)) - 3;
            y0 = $urandom_range(0, 205);
            y1 = y0 + int'($urandom_range(0, 6)) - 3;
            if (x1 < 0) x1 = 0;
            if (y1 < 0) y1 = 0;
            xl = (x0 < x1) ? x0 : x1;
            xh = (x0 < x1) ? x1 : x0;
            yl = (y0 < y1) ? y0 : y1;
            yh = (y0 < y1) ? y1 : y0;
            for (int y = yl; y <= yh && y < 200; y++)
                for (int x = xl; x <= xh && x < 320; x++) poke(x, y, bit'($urandom_range(0, 1)));
            run_cmd($sformatf("random%0d", t), op, x0, x1, y0, y1);
            check_region($sformatf("random%0d", t), xl, xh, yl, yh);
        end
    endtask

    initial begin
        reset         = 1'b1;
        poke_en       = 1'b0;
        poke_v        = 1'b0;
        poke_x        = '0;
        poke_y        = '0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'd0;
        bus.cmd_x0    = '0;
        bus.cmd_x1    = '0;
        bus.cmd_y0    = '0;
        bus.cmd_y1    = '0;
        test_reset();
        test_single_fill();
        test_swapped();
        test_invert();
        test_clip();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule

// File: doc/rect_engine.md
# rect_engine

Rectangle raster engine driving port B of the 320x200 1-bit GPU framebuffer. It accepts one rectangle command at a time: fill with 0, fill with 1, or invert. It walks the clipped rectangle in raster order and issues single-pixel read/write requests through the framebuffer's `read_b`/`write_b`/`rdy_b` handshake. It is the sole port-B master and sits between the command decoder and the framebuffer.

## Interface
No parameters. Screen size is fixed at 320x200.
- `clk_b` in 1: port-B clock.
- `reset` in 1: reset, synchronous, active-high.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: engine idle; command accepted on `cmd_valid && cmd_ready`.
- `cmd_op` in 2: 00 fill 0, 01 fill 1, 10 invert, 11 no-op.
- `cmd_x0`, `cmd_x1` in 9 each: corner x coordinates, any order.
- `cmd_y0`, `cmd_y1` in 8 each: corner y coordinates, any order.
- `done` out 1: one-cycle pulse when a command completes.
- `x_b` out 9, `y_b` out 8: pixel address to the framebuffer.
- `read_b` out 1, `write_b` out 1: request strobes to the framebuffer.
- `in_b` out 1: write data.
- `out_b` in 1: read data from the framebuffer.
- `rdy_b` in 1: framebuffer idle.

## Operation
- On accept, register the normalised bounds:
  - xmin = min(x0,x1), xmax = min(max(x0,x1), 319).
  - ymin = min(y0,y1), ymax = min(max(y0,y1), 199).
- Empty command: xmin > 319, ymin > 199, or op 11. It makes no RAM access.
- Traversal order is y outer, x inner: (xmin,ymin), (xmin+1,ymin) … (xmax,ymax). At x = xmax, x wraps to xmin and y increments.
- Counters are 9 and 8 bits. The clip guarantees they never wrap past the screen.
- States:
  - IDLE: `cmd_ready`=1. On accept: if empty, go to FIN; else op 10 goes to RD_REQ, ops 00/01 go to WR_REQ.
  - RD_REQ: `read_b`=1. Exit to RD_WAIT in the cycle after a cycle with `rdy_b`=1.
  - RD_WAIT: wait for `rdy_b`=1. In that cycle latch inv = ~`out_b`, then go to WR_REQ.
  - WR_REQ: `write_b`=1. `in_b` = `cmd_op[0]` for fills, or inv for invert. Exit to WR_WAIT after a cycle with `rdy_b`=1.
  - WR_WAIT: wait for `rdy_b`=1. If last pixel, go to FIN; else advance coordinates and go to RD_REQ (invert) or WR_REQ (fill).
  - FIN: `done`=1 for one cycle, then go to IDLE.
- Request outputs are decoded from registered state and registered coordinates; they are glitch-free.
  - Exactly one of `read_b`/`write_b` is asserted per request, and only while in RD_REQ/WR_REQ.
  - `x_b`/`y_b`/`in_b` are stable for the whole request.
  - Holding a request while `rdy_b`=0 is legal. The framebuffer samples only when idle.
- `cmd_valid` is ignored while `cmd_ready`=0. Command inputs are sampled only at accept.
- Reset in any state:
  - Next cycle is IDLE.
  - All outputs are 0 except `cmd_ready`=1.
  - The command in flight is discarded with no `done` pulse. The framebuffer is reset by the same signal.

## Timing
- Reset values: `cmd_ready`=1, `done`=0, `read_b`=0, `write_b`=0, `in_b`=0, `x_b`=0, `y_b`=0.
- Accept on the edge ending cycle c. Cycle c+1 is the first REQ state, or FIN for an empty command.
- The framebuffer takes the request at the edge ending cycle t.
  - Write: `rdy_b`=0 at t+1, 1 at t+2.
  - Read: `rdy_b`=0 at t+1 and t+2; `rdy_b`=1 with valid `out_b` at t+3.
- Fill: 3 cycles per pixel. For N pixels, `done` is high in cycle c+1+3N.
- Invert: 7 cycles per pixel. `done` is high in cycle c+1+7N.
- Empty command: `done` is high in cycle c+1.
- IDLE with `cmd_ready`=1 follows `done`, so the next accept happens no earlier than c+2+3N (fill) or c+2+7N (invert).
- `cmd_ready` drops the cycle after accept.

## Test plan
- **Single-pixel fill:** reset, then op 01 at (5,7)-(5,7).
  - One `write_b` pulse with x=5, y=7, `in_b`=1.
  - `done` 4 cycles after accept; pixel reads back 1.
- **Swapped corners:** op 00 at (12,3)-(10,2).
  - Write order: (10,2), (11,2), (12,2), (10,3), (11,3), (12,3), all with `in_b`=0.
  - `done` at c+19.
- **Invert:** op 10 on (0,0)-(1,0) over RAM holding 1,0.
  - Read, write, read, write sequence; writes are 0 then 1.
  - `done` at c+15; RAM holds 0,1.
- **Clipping:** op 01 at (300,190)-(400,250).
  - 200 writes; last address (319,199).
  - Corners (320,*) and (*,200) never appear. `done` at c+601.
- **Empty and back-to-back:** op 01 at (330,0)-(340,5), then op 11 immediately after.
  - Each gives `done` at c+1 with no RAM strobe.
  - A `cmd_valid` held during the busy period is accepted only after `done`.
- **Reset mid-operation:** reset asserted during the 10th pixel of a 4x4 invert.
  - Next cycle: IDLE, `cmd_ready`=1, no `done`, no further strobes.
  - A new fill then completes normally.
